// File: rtl/tag_rx_pkg.sv
// Shared definitions for the tag RX datapath: controller state codes and
// the accumulator width rule for integrate-and-dump stages.
package tag_rx_pkg;

    typedef enum logic [1:0] {
        INIT      = 2'b00,
        LOC_SYNCH = 2'b01,
        HOP_SYNCH = 2'b10,
        HOP_RX    = 2'b11
    } rx_state_e;

    // A sum of 2^log2_decim full-scale samples needs log2_decim extra bits.
    function automatic int acc_width(input int data_w, input int log2_decim);
        return data_w + log2_decim;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Small synchronous FIFO with first-word fall-through: the head entry is
// always presented on rd_data_o while the FIFO is non-empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (count_q == (AW+1)'(0));
    assign full_o    = (count_q == COUNT_FULL);
    assign do_pop_s  = rd_en_i & ~empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push_s = wr_en_i & (~full_o | do_pop_s);
    assign rd_data_o = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/tag_rx_hop_integrator.sv
// Integrate-and-dump of the tag RX IQ stream over fixed windows during each
// HOP_RX interval; tagged window sums are queued for a valid/ready consumer.
module tag_rx_hop_integrator
    import tag_rx_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int BIT_CNT_WIDTH = 7,
    parameter int LOG2_DECIM    = 8,
    parameter int WIN_WIDTH     = 12,
    parameter int FIFO_AW       = 2,
    parameter int DROP_WIDTH    = 16,
    localparam int ACC_WIDTH    = acc_width(DATA_WIDTH, LOG2_DECIM)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic signed [DATA_WIDTH-1:0]    irx_in,
    input  logic signed [DATA_WIDTH-1:0]    qrx_in,
    input  logic [1:0]                      rx_state,
    input  logic [BIT_CNT_WIDTH-1:0]        nhop,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [ACC_WIDTH-1:0]     out_i,
    output logic signed [ACC_WIDTH-1:0]     out_q,
    output logic [BIT_CNT_WIDTH-1:0]        out_hop,
    output logic [WIN_WIDTH-1:0]            out_win,
    output logic                            hop_done,
    output logic [WIN_WIDTH-1:0]            hop_windows,
    output logic [DROP_WIDTH-1:0]           drop_cnt
);
    localparam int ENTRY_W = 2*ACC_WIDTH + BIT_CNT_WIDTH + WIN_WIDTH;
    localparam logic [LOG2_DECIM-1:0] SAMP_LAST = '1;

    logic                         prev_rx_q;
    logic signed [ACC_WIDTH-1:0]  acc_i_q, acc_q_q;
    logic [LOG2_DECIM-1:0]        samp_cnt_q;
    logic [WIN_WIDTH-1:0]         win_cnt_q;
    logic [BIT_CNT_WIDTH-1:0]     hop_tag_q;
    logic                         hop_done_q;
    logic [WIN_WIDTH-1:0]         hop_windows_q;
    logic [DROP_WIDTH-1:0]        drop_cnt_q;

    logic                         rx_s, dump_s, pop_s, full_s, empty_s, drop_s;
    logic signed [ACC_WIDTH-1:0]  samp_i_s, samp_q_s, sum_i_s, sum_q_s;
    logic [ENTRY_W-1:0]           wr_entry_s, head_s;

    assign rx_s     = (rx_state == HOP_RX);
    assign samp_i_s = {{LOG2_DECIM{irx_in[DATA_WIDTH-1]}}, irx_in};
    assign samp_q_s = {{LOG2_DECIM{qrx_in[DATA_WIDTH-1]}}, qrx_in};
    assign sum_i_s  = acc_i_q + samp_i_s;
    assign sum_q_s  = acc_q_q + samp_q_s;

    // The window's last sample is folded in on the fly so the entry lands one edge later.
    assign dump_s     = rx_s & prev_rx_q & (samp_cnt_q == SAMP_LAST);
    assign wr_entry_s = {sum_i_s, sum_q_s, hop_tag_q, win_cnt_q};
    assign out_valid  = ~empty_s;
    assign pop_s      = out_valid & out_ready;
    assign drop_s     = dump_s & full_s & ~pop_s;

    sync_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (dump_s),
        .wr_data_i (wr_entry_s),
        .rd_en_i   (pop_s),
        .rd_data_o (head_s),
        .full_o    (full_s),
        .empty_o   (empty_s)
    );

    assign {out_i, out_q, out_hop, out_win} = head_s;
    assign hop_done    = hop_done_q;
    assign hop_windows = hop_windows_q;
    assign drop_cnt    = drop_cnt_q;

    // Hop tracking, accumulation, window counting and drop accounting
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_rx_q     <= 1'b0;
            acc_i_q       <= '0;
            acc_q_q       <= '0;
            samp_cnt_q    <= '0;
            win_cnt_q     <= '0;
            hop_tag_q     <= '0;
            hop_done_q    <= 1'b0;
            hop_windows_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            prev_rx_q  <= rx_s;
            hop_done_q <= 1'b0;
            if (drop_s && (drop_cnt_q != {DROP_WIDTH{1'b1}})) begin
                drop_cnt_q <= drop_cnt_q + DROP_WIDTH'(1);
            end
            if (rx_s && !prev_rx_q) begin
                hop_tag_q  <= nhop;
                win_cnt_q  <= '0;
                acc_i_q    <= samp_i_s;
                acc_q_q    <= samp_q_s;
                samp_cnt_q <= LOG2_DECIM'(1);
            end else if (rx_s) begin
                if (samp_cnt_q == SAMP_LAST) begin
                    acc_i_q    <= '0;
                    acc_q_q    <= '0;
                    samp_cnt_q <= '0;
                    win_cnt_q  <= win_cnt_q + WIN_WIDTH'(1);
                end else begin
                    acc_i_q    <= sum_i_s;
                    acc_q_q    <= sum_q_s;
                    samp_cnt_q <= samp_cnt_q + LOG2_DECIM'(1);
                end
            end else begin
                // Any partial window is abandoned when the hop ends.
                acc_i_q    <= '0;
                acc_q_q    <= '0;
                samp_cnt_q <= '0;
                if (prev_rx_q) begin
                    hop_done_q    <= 1'b1;
                    hop_windows_q <= win_cnt_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_tag_rx_hop_integrator.sv
// Directed bench for tag_rx_hop_integrator: hand-computed window sums, tags,
// backpressure/drop behaviour, partial windows and mid-hop reset.
module tb_tag_rx_hop_integrator;
    localparam int DW = 16, BW = 7, L2D = 8, WW = 12, FAW = 2, DRW = 16;
    localparam int ACCW = DW + L2D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset;
    logic signed [DW-1:0]   irx_in, qrx_in;
    logic [1:0]             rx_state;
    logic [BW-1:0]          nhop;
    logic                   out_valid, out_ready;
    logic signed [ACCW-1:0] out_i, out_q;
    logic [BW-1:0]          out_hop;
    logic [WW-1:0]          out_win;
    logic                   hop_done;
    logic [WW-1:0]          hop_windows;
    logic [DRW-1:0]         drop_cnt;

    tag_rx_hop_integrator #(
        .DATA_WIDTH(DW), .BIT_CNT_WIDTH(BW), .LOG2_DECIM(L2D),
        .WIN_WIDTH(WW), .FIFO_AW(FAW), .DROP_WIDTH(DRW)
    ) dut (
        .clk(clk), .reset(reset), .irx_in(irx_in), .qrx_in(qrx_in),
        .rx_state(rx_state), .nhop(nhop), .out_valid(out_valid),
        .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
        .out_hop(out_hop), .out_win(out_win), .hop_done(hop_done),
        .hop_windows(hop_windows), .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic signed [ACCW-1:0] i;
        logic signed [ACCW-1:0] q;
        logic [BW-1:0]          hop;
        logic [WW-1:0]          win;
    } ent_t;

    ent_t          popped[$];
    int            hd_cnt = 0;
    logic [WW-1:0] hd_last = '0;
    int            n_checks = 0;
    int            n_errors = 0;

    // Consumer-side monitor: records accepted entries and hop_done pulses
    always @(negedge clk) begin
        if (out_valid && out_ready) popped.push_back('{out_i, out_q, out_hop, out_win});
        if (hop_done) begin
            hd_cnt  = hd_cnt + 1;
            hd_last = hop_windows;
        end
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_hop(input int n, input int hop, input int iv, input int qv, input int idle);
        nhop     = BW'(hop);
        irx_in   = DW'(iv);
        qrx_in   = DW'(qv);
        rx_state = 2'b11;
        step(n);
        rx_state = 2'b10;
        step(idle);
    endtask

    task automatic check_entry(input string tag, input int idx, input longint ei,
                               input longint eq, input longint eh, input longint ew);
        ent_t e;
        e = '0;
        if (idx < popped.size()) e = popped[idx];
        check_eq({tag, ".i"}, longint'($signed(e.i)), ei);
        check_eq({tag, ".q"}, longint'($signed(e.q)), eq);
        check_eq({tag, ".hop"}, longint'(e.hop), eh);
        check_eq({tag, ".win"}, longint'(e.win), ew);
    endtask

    int b, h;

    initial begin
        reset = 1'b1; irx_in = '0; qrx_in = '0; rx_state = 2'b00; nhop = '0; out_ready = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        check_eq("rst.valid", out_valid, 0);
        check_eq("rst.drop", drop_cnt, 0);
        check_eq("rst.hop_done", hop_done, 0);
        check_eq("rst.hop_windows", hop_windows, 0);
        check_eq("rst.out_i", out_i, 0);

        // Constant input over two windows
        b = popped.size(); h = hd_cnt;
        run_hop(512, 5, 100, -3, 4);
        check_eq("const.n", popped.size() - b, 2);
        check_entry("const.e0", b, 25600, -768, 5, 0);
        check_entry("const.e1", b + 1, 25600, -768, 5, 1);
        check_eq("const.hd", hd_cnt - h, 1);
        check_eq("const.hw", hd_last, 2);

        // Full-scale extremes
        b = popped.size();
        run_hop(256, 2, -32768, 32767, 4);
        run_hop(256, 2, 32767, -32768, 4);
        check_entry("ext.e0", b, -8388608, 8388352, 2, 0);
        check_entry("ext.e1", b + 1, 8388352, -8388608, 2, 0);

        // Backpressure: 6 windows into a 4-deep FIFO
        out_ready = 1'b0; nhop = 7'd9; irx_in = 16'sd1; qrx_in = -16'sd1; rx_state = 2'b11;
        step(255);
        check_eq("lat.pre", out_valid, 0);
        step(1);
        check_eq("lat.post", out_valid, 1);
        check_eq("lat.out_i", out_i, 256);
        step(1280);
        rx_state = 2'b10;
        step(4);
        check_eq("bp.drop", drop_cnt, 2);
        check_eq("bp.hold_win", out_win, 0);
        check_eq("bp.hold_hop", out_hop, 9);
        check_eq("bp.hw", hd_last, 6);
        b = popped.size();
        out_ready = 1'b1;
        step(6);
        check_eq("bp.n", popped.size() - b, 4);
        for (int k = 0; k < 4; k++) check_entry($sformatf("bp.e%0d", k), b + k, 256, -256, 9, k);
        check_eq("bp.empty", out_valid, 0);

        // Partial window then a fresh hop
        b = popped.size();
        run_hop(300, 3, 2, 5, 4);
        check_eq("part.n", popped.size() - b, 1);
        check_entry("part.e0", b, 512, 1280, 3, 0);
        check_eq("part.hw", hd_last, 1);
        run_hop(256, 4, -7, 1, 4);
        check_entry("part.next", b + 1, -1792, 256, 4, 0);

        // Back-to-back hops separated by HOP_SYNCH
        b = popped.size(); h = hd_cnt;
        run_hop(256, 0, 10, 20, 10);
        run_hop(256, 1, -10, -20, 4);
        check_eq("b2b.n", popped.size() - b, 2);
        check_entry("b2b.e0", b, 2560, 5120, 0, 0);
        check_entry("b2b.e1", b + 1, -2560, -5120, 1, 0);
        check_eq("b2b.hd", hd_cnt - h, 2);

        // Reset mid-window with two entries pending
        out_ready = 1'b0; nhop = 7'd6; irx_in = 16'sd1; qrx_in = 16'sd1; rx_state = 2'b11;
        step(612);
        check_eq("mid.pending", out_valid, 1);
        h = hd_cnt;
        reset = 1'b1;
        step(1);
        reset = 1'b0; rx_state = 2'b00;
        check_eq("mid.valid", out_valid, 0);
        check_eq("mid.drop", drop_cnt, 0);
        check_eq("mid.hop_done", hop_done, 0);
        step(4);
        check_eq("mid.no_hd", hd_cnt - h, 0);
        out_ready = 1'b1;
        b = popped.size();
        run_hop(256, 7, 3, -4, 4);
        check_eq("mid.n", popped.size() - b, 1);
        check_entry("mid.e0", b, 768, -1024, 7, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tag_rx_hop_integrator.md
Name: tag_rx_hop_integrator

Overview:
- Sits directly downstream of the tag RX controller. Consumes its IQ output stream and its rx_state / nhop indications.
- During each HOP_RX interval, integrates I and Q over fixed 2^LOG2_DECIM-sample windows (integrate-and-dump).
- Tags each window result with the hop index and the window index within that hop.
- Buffers results in a small FIFO with a valid/ready output, counts dropped results, and pulses a per-hop done indication with the hop's window count.

Parameters:
- DATA_WIDTH, 16, signed I/Q sample width.
- BIT_CNT_WIDTH, 7, hop index width.
- LOG2_DECIM, 8, window length = 2^LOG2_DECIM samples.
- WIN_WIDTH, 12, window-index / window-count width.
- FIFO_AW, 2, FIFO depth = 2^FIFO_AW entries.
- DROP_WIDTH, 16, drop counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- irx_in  in  DATA_WIDTH  signed I sample, one per clk.
- qrx_in  in  DATA_WIDTH  signed Q sample.
- rx_state  in  2  controller state; 2'b11 = HOP_RX, all other codes = not receiving.
- nhop  in  BIT_CNT_WIDTH  current hop index from the controller.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_i  out  DATA_WIDTH+LOG2_DECIM  signed I window sum.
- out_q  out  DATA_WIDTH+LOG2_DECIM  signed Q window sum.
- out_hop  out  BIT_CNT_WIDTH  hop tag of the head entry.
- out_win  out  WIN_WIDTH  window index within the hop of the head entry.
- hop_done  out  1  one-cycle pulse when a HOP_RX interval ends.
- hop_windows  out  WIN_WIDTH  windows completed in the hop just ended; valid with hop_done, holds its value otherwise.
- drop_cnt  out  DROP_WIDTH  saturating count of results lost to a full FIFO.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: all outputs 0; FIFO empty; accumulators, sample counter, window counter, hop latch and prev_rx all 0.
- Reset mid-operation: discards any partial window and all FIFO contents. No hop_done is generated.
- ACC_WIDTH = DATA_WIDTH+LOG2_DECIM (localparam). Inputs are sign-extended into the accumulator. The full-scale sum never overflows; no saturation or truncation.
- rx = (rx_state == 2'b11). prev_rx is rx registered.
- States: IDLE (rx=0) and INTEG (rx=1), derived from rx and prev_rx; no other internal FSM.
- Hop entry (rx & !prev_rx):
  - latch nhop into hop_tag;
  - win_cnt <= 0;
  - acc_i/acc_q <= sign-extended current sample;
  - samp_cnt <= 1.
- INTEG, continuing cycle:
  - if samp_cnt == 2^LOG2_DECIM-1: push {acc_i+irx_in, acc_q+qrx_in, hop_tag, win_cnt}; acc <= 0; samp_cnt <= 0; win_cnt <= win_cnt+1 (wraps modulo 2^WIN_WIDTH).
  - else: acc <= acc + sample; samp_cnt <= samp_cnt+1.
  - samp_cnt is LOG2_DECIM bits wide.
- No dead cycles between windows: sample N+1 after a dump starts the next window.
- Latency: last sample of a window at cycle t -> entry in FIFO at t+1. If the FIFO was empty, out_valid=1 at t+1.
- Hop exit (!rx & prev_rx):
  - hop_done=1 for exactly one cycle, on the first non-HOP_RX cycle;
  - hop_windows <= win_cnt, including a push made on the previous cycle;
  - partial window (samp_cnt != 0) is discarded; acc and samp_cnt are cleared.
- IDLE: samples ignored; accumulators hold 0.
- FIFO:
  - synchronous; pop when out_valid & out_ready;
  - outputs driven directly from the head entry (first-word fall-through);
  - out_* hold stable while out_valid & !out_ready.
- Simultaneous push and pop:
  - when full, both succeed with no drop;
  - when empty, the push is not visible until the next cycle.
- Push while full and no pop: entry discarded; drop_cnt increments and saturates at all-ones. Counters and flags otherwise unaffected.
- A new hop entering while results of the previous hop remain in the FIFO is legal. Entries keep their own hop tags.

Decomposition:
- Shared package tag_rx_pkg:
  - rx_state encodings INIT=2'b00, LOC_SYNCH=2'b01, HOP_SYNCH=2'b10, HOP_RX=2'b11;
  - ACC_WIDTH derivation helper.
- One sub-module: sync_fifo_fwft (parameterised width and FIFO_AW, with full/empty and first-word fall-through).
- The integrator and counters stay in the top module.

Test Plan:
- Constant input: irx_in=100, qrx_in=-3 for 512 HOP_RX cycles, nhop=5, out_ready=1 -> two entries out_i=25600, out_q=-768, out_hop=5, out_win=0 then 1; hop_done pulse with hop_windows=2.
- Extreme input: irx_in=-32768 for 256 cycles -> out_i=-8388608 exactly. irx_in=32767 -> out_i=8388352.
- Backpressure: out_ready=0, 6 windows -> 4 entries held, drop_cnt=2. Then out_ready=1 -> out_win sequence 0,1,2,3.
- Partial window: HOP_RX for 300 cycles -> one entry; hop_windows=1; the 44-sample remainder is discarded. The next hop's first sum reflects only its own samples.
- Back-to-back hops: HOP_RX (nhop=0) 256 cycles, HOP_SYNCH 10 cycles, HOP_RX (nhop=1) 256 cycles -> entries tagged hop 0/win 0 and hop 1/win 0; two hop_done pulses.
- Reset mid-window, after 100 samples with 2 FIFO entries pending -> next cycle out_valid=0, drop_cnt=0, no hop_done. A fresh 256-sample hop yields out_win=0 with the correct sum.
